// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between multicycle_ctrl (master) and the datapath and memories (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] instr;
  logic                  alu_zero;
  logic                  imem_ready;
  logic                  dmem_ready;
  logic                  imem_req;
  logic                  dmem_req;
  logic                  ir_en;
  logic                  pc_en;
  logic                  pc_src;
  logic                  reg_write;
  logic                  result_src;
  logic                  alu_src_b;
  logic [2:0]            alu_ctrl;
  logic [2:0]            imm_src;
  logic                  illegal_instr;
  logic [DATA_WIDTH-1:0] instret;

  modport master (
    input  instr, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_en, pc_en, pc_src, reg_write, result_src, alu_src_b,
           alu_ctrl, imm_src, illegal_instr, instret
  );

  modport slave (
    output instr, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, ir_en, pc_en, pc_src, reg_write, result_src, alu_src_b,
           alu_ctrl, imm_src, illegal_instr, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (fetch/decode/exec/mem/wb) for addi, bne and lw, with retire counter.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OpAddi = 7'b0010011;
  localparam logic [6:0] OpBne  = 7'b1100011;
  localparam logic [6:0] OpLw   = 7'b0000011;

  localparam logic [2:0] AluSum = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] ImmI   = 3'd0;
  localparam logic [2:0] ImmB   = 3'd3;

  localparam logic [DATA_WIDTH-1:0] InstretOne = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
`else
  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instret_q;
  logic [6:0]            opcode;
  logic                  is_legal;
  logic                  unused_instr;

  logic       imem_req, dmem_req, ir_en, pc_en, pc_src;
  logic       reg_write, result_src, alu_src_b, illegal_instr;
  logic [2:0] alu_ctrl, imm_src;

  assign opcode       = bus.instr[6:0];
  assign unused_instr = ^bus.instr[DATA_WIDTH-1:7];
  assign is_legal     = opcode inside {OpAddi, OpBne, OpLw};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (bus.imem_ready) state_d = StDecode;
      StDecode: begin
        if (is_legal) begin
          state_d = StExec;
        end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
`endif
        end
      end
      StExec:   state_d = (opcode == OpLw) ? StMem : StFetch;
      StMem:    if (bus.dmem_ready) state_d = StWb;
      StWb:     state_d = StFetch;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      StTrap:   state_d = StTrap;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // Strobes are decoded from the current state and gated off while reset is held,
  // so imem_req stays low until the first cycle after release.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    result_src    = 1'b0;
    alu_src_b     = 1'b0;
    alu_ctrl      = AluSum;
    imm_src       = ImmI;
    illegal_instr = 1'b0;
    if (rst) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_en    = bus.imem_ready;
        end
        StDecode: begin
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          if (!is_legal) pc_en = 1'b1;
`endif
        end
        StExec: begin
          case (opcode)
            OpAddi: begin
              alu_ctrl  = AluSum;
              alu_src_b = 1'b1;
              imm_src   = ImmI;
              reg_write = 1'b1;
              pc_en     = 1'b1;
            end
            OpBne: begin
              alu_ctrl = AluSub;
              imm_src  = ImmB;
              pc_en    = 1'b1;
              pc_src   = ~bus.alu_zero;
            end
            OpLw: begin
              alu_ctrl  = AluSum;
              alu_src_b = 1'b1;
              imm_src   = ImmI;
              dmem_req  = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          // Address path held stable for the whole access.
          dmem_req  = 1'b1;
          alu_ctrl  = AluSum;
          alu_src_b = 1'b1;
          imm_src   = ImmI;
        end
        StWb: begin
          reg_write  = 1'b1;
          result_src = 1'b1;
          pc_en      = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        StTrap:  illegal_instr = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_en) instret_q <= instret_q + InstretOne;
    end
  end

  assign bus.imem_req      = imem_req;
  assign bus.dmem_req      = dmem_req;
  assign bus.ir_en         = ir_en;
  assign bus.pc_en         = pc_en;
  assign bus.pc_src        = pc_src;
  assign bus.reg_write     = reg_write;
  assign bus.result_src    = result_src;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_ctrl      = alu_ctrl;
  assign bus.imm_src       = imm_src;
  assign bus.illegal_instr = illegal_instr;
  assign bus.instret       = instret_q;

endmodule
